// File: rtl/seg_scan.sv
// seg_scan: multiplexed driver for an NDIG-digit common-anode 7-segment display.
// Optional build macro SEG_LZB_EN enables leading-zero blanking.
module seg_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 1000,
    parameter int NDIG      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*NDIG-1:0]     data,
    input  logic [NDIG-1:0]       en,
    output logic [NDIG-1:0]       an,
    output logic [6:0]            seg
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic {BLANK, SHOW} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [4*NDIG-1:0]   frame_data;
    logic [NDIG-1:0]     frame_en;
    logic                slot_end, blank_end, snap;
    logic [3:0]          nibble;
    logic [NDIG-1:0]     lzb_dark;
    logic [NDIG-1:0]     an_nxt;
    logic [6:0]          seg_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign slot_end  = (cnt == CW'(SCAN_DIV - 1));
    assign blank_end = (cnt == CW'(BLANK_CYC - 1));
    // Snapshot at the first cycle of every frame, so a frame never mixes old and new data.
    assign snap      = (state == BLANK) && (idx == '0) && (cnt == '0);
    assign nibble    = frame_data[{idx, 2'b00} +: 4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= '0;
            frame_data <= '0;
            frame_en   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= slot_end ? '0 : cnt + CW'(1);
            if (state == SHOW && slot_end)
                idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);
            if (snap) begin
                frame_data <= data;
                frame_en   <= en;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BLANK:   if (blank_end) state_nxt = SHOW;
            SHOW:    if (slot_end)  state_nxt = BLANK;
            default: state_nxt = BLANK;
        endcase
    end

`ifdef SEG_LZB_EN
    // Digit i goes dark when it and every higher nibble are zero; digit 0 is exempt.
    always_comb begin
        lzb_dark = '0;
        for (int i = 1; i < NDIG; i++)
            lzb_dark[i] = ((frame_data >> (4 * i)) == '0);
    end
`else
    assign lzb_dark = '0;
`endif

    always_comb begin
        an_nxt  = '1;
        seg_nxt = 7'h7F;
        if (state == SHOW && frame_en[idx] && !lzb_dark[idx]) begin
            an_nxt  = ~(NDIG'(1) << idx);
            seg_nxt = hex7(nibble);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= '1;
            seg <= 7'h7F;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: scoreboard bench for seg_scan with a cycle-indexed reference model.
// Honours SEG_LZB_EN the same way the design does.
module tb_seg_scan;

    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
    localparam int NDIG      = 8;
    localparam int FRAME     = SCAN_DIV * NDIG;
    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data;
    logic [7:0]  en;
    logic [7:0]  an;
    logic [6:0]  seg;

    int          checks = 0;
    int          passed = 0;
    int          cyc    = 0;
    int          tick   = 0;
    logic [31:0] snapD  = '0;
    logic [7:0]  snapE  = '0;
    logic [14:0] expq[$];
    logic [14:0] expv;

    seg_scan #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .NDIG(NDIG)) dut (
        .clk  (clk),
        .rst  (rst),
        .data (data),
        .en   (en),
        .an   (an),
        .seg  (seg)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) passed++;
        else $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    endtask

    task automatic applyStimulus(input logic [31:0] d, input logic [7:0] e);
        @(negedge clk);
        data = d;
        en   = e;
    endtask

    task automatic waitAn(input logic [7:0] v, input bit want, input string tag);
        int n;
        n = 0;
        while (((an == v) != want) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) checkOutput({tag, "_timeout"}, {24'b0, an}, {24'b0, v});
    endtask

    // Expected outputs for the cycle p since reset release, derived from slot arithmetic.
    function automatic logic [14:0] model(input int p);
        int   slot, phase;
        bit   dark;
        logic [3:0] nib;
        slot  = (p / SCAN_DIV) % NDIG;
        phase = p % SCAN_DIV;
        dark  = (phase < BLANK_CYC) || !snapE[slot];
`ifdef SEG_LZB_EN
        if (slot > 0 && (snapD >> (4 * slot)) == 32'h0) dark = 1'b1;
`endif
        nib = snapD[4*slot +: 4];
        if (dark) return {8'hFF, 7'h7F};
        return {~(8'd1 << slot), HEX[nib]};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            tick++;
            if (rst) begin
                cyc = 0;
                expq.push_back({8'hFF, 7'h7F});
            end else begin
                expq.push_back(model(cyc));
                if (cyc % FRAME == 0) begin
                    snapD = data;
                    snapE = en;
                end
                cyc++;
            end
            #1;
            expv = expq.pop_front();
            checkOutput("scan", {17'b0, an, seg}, {17'b0, expv});
            checkOutput("onehot", 32'($countones(~an) <= 1), 32'd1);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0, t1;
        rst  = 1'b1;
        data = 32'h76543210;
        en   = 8'hFF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); checkOutput("rel_an0", {24'b0, an}, 32'hFF);
        @(negedge clk); checkOutput("rel_an1", {24'b0, an}, 32'hFF);
        @(negedge clk); checkOutput("rel_an2", {24'b0, an}, 32'hFE);

        waitAn(8'hFD, 1, "dig1");
        checkOutput("dig1_seg", {25'b0, seg}, 32'h79);
        waitAn(8'h7F, 1, "dig7");
        checkOutput("dig7_seg", {25'b0, seg}, 32'h78);

        // Asynchronous reset in the middle of digit 3.
        waitAn(8'hF7, 1, "dig3");
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_an", {24'b0, an}, 32'hFF);
        checkOutput("arst_seg", {25'b0, seg}, 32'h7F);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); checkOutput("rel2_an0", {24'b0, an}, 32'hFF);
        @(negedge clk); checkOutput("rel2_an1", {24'b0, an}, 32'hFF);
        @(negedge clk); checkOutput("rel2_an2", {24'b0, an}, 32'hFE);

        waitAn(8'hF7, 1, "hold3");
        data = 32'hFFFFFFFF;
        waitAn(8'h7F, 1, "hold7");
        checkOutput("hold7_seg", {25'b0, seg}, 32'h78);
        waitAn(8'hFE, 0, "hold_leave");
        waitAn(8'hFE, 1, "hold_new");
        checkOutput("new0_seg", {25'b0, seg}, 32'h0E);

        applyStimulus(32'hFFFFFFFF, 8'h0F);
        waitAn(8'hFE, 0, "mask_a");
        waitAn(8'hFE, 1, "mask_b");
        t0 = tick;
        waitAn(8'hFE, 0, "mask_c");
        waitAn(8'hFE, 1, "mask_d");
        t1 = tick;
        checkOutput("frame_period", 32'(t1 - t0), 32'(FRAME));

        applyStimulus(32'h00000A05, 8'hFF);
        waitAn(8'hFE, 0, "lzb_a");
        waitAn(8'hFE, 1, "lzb_b");
        checkOutput("lzb_d0", {25'b0, seg}, 32'h12);
        waitAn(8'hFD, 1, "lzb_d1");
        checkOutput("lzb_d1", {25'b0, seg}, 32'h40);
        waitAn(8'hFB, 1, "lzb_d2");
        checkOutput("lzb_d2", {25'b0, seg}, 32'h08);
`ifndef SEG_LZB_EN
        waitAn(8'h7F, 1, "lzb_d7");
        checkOutput("nolzb_d7", {25'b0, seg}, 32'h40);
`endif
        repeat (FRAME) @(negedge clk);

        for (int i = 0; i < 10 * FRAME; i++) begin
            if ($urandom_range(0, 15) == 0) applyStimulus($urandom, 8'($urandom));
            else @(negedge clk);
        end

        @(negedge clk);
        checkOutput("queue_empty", 32'(expq.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
